// File: rtl/div_radix.sv
// Restoring integer divider retiring SPC quotient bits per clock (IDLE -> CALC -> FIX).
// Signed operation is compiled in only when DIV_SIGNED_EN is defined; otherwise sgn is ignored and ovf stays 0.
module div_radix #(
  parameter int DSZ = 32,
  parameter int SPC = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           sgn,
  input  logic [DSZ-1:0] x,
  input  logic [DSZ-1:0] y,
  output logic           busy,
  output logic           done,
  output logic           dbz,
  output logic           ovf,
  output logic [DSZ-1:0] q,
  output logic [DSZ-1:0] r
);

  localparam int N  = DSZ / SPC;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state_reg, state_next;

  logic [DSZ-1:0] rem_reg, rem_next;
  logic [DSZ-1:0] quo_reg, quo_next;
  logic [DSZ-1:0] den_reg, den_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [DSZ-1:0] q_reg, q_next;
  logic [DSZ-1:0] r_reg, r_next;
  logic           dbz_reg, dbz_next;
  logic           ovf_reg, ovf_next;
  logic           done_reg, done_next;

  logic [DSZ-1:0] x_mag, y_mag;

`ifdef DIV_SIGNED_EN
  logic x_neg, y_neg, ovf_hit;
  logic qneg_reg, qneg_next;
  logic rneg_reg, rneg_next;
  logic ovfp_reg, ovfp_next;

  assign x_neg   = sgn & x[DSZ-1];
  assign y_neg   = sgn & y[DSZ-1];
  assign x_mag   = x_neg ? -x : x;
  assign y_mag   = y_neg ? -y : y;
  assign ovf_hit = sgn && (x == {1'b1, {(DSZ-1){1'b0}}}) && (y == {DSZ{1'b1}});
`else
  logic unused_sgn;

  assign unused_sgn = sgn;
  assign x_mag      = x;
  assign y_mag      = y;
`endif

  // Unrolled restoring steps: the dividend shifts out of quo while quotient bits shift in.
  // The shifted remainder needs DSZ+1 bits; after the compare it always fits in DSZ again.
  logic [DSZ-1:0] srem [0:SPC];
  logic [DSZ-1:0] squo [0:SPC];

  assign srem[0] = rem_reg;
  assign squo[0] = quo_reg;

  for (genvar gi = 0; gi < SPC; gi++) begin : g_step
    logic [DSZ:0] shifted;
    logic [DSZ:0] diff;

    assign shifted      = {srem[gi], squo[gi][DSZ-1]};
    assign diff         = shifted - {1'b0, den_reg};
    assign srem[gi+1]   = diff[DSZ] ? shifted[DSZ-1:0] : diff[DSZ-1:0];
    assign squo[gi+1]   = {squo[gi][DSZ-2:0], ~diff[DSZ]};
  end

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    quo_next   = quo_reg;
    den_next   = den_reg;
    cnt_next   = cnt_reg;
    q_next     = q_reg;
    r_next     = r_reg;
    dbz_next   = dbz_reg;
    ovf_next   = ovf_reg;
    done_next  = 1'b0;
`ifdef DIV_SIGNED_EN
    qneg_next  = qneg_reg;
    rneg_next  = rneg_reg;
    ovfp_next  = ovfp_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (y == '0) begin
            // Divide by zero resolves immediately; results are visible in the FIX cycle.
            q_next     = '1;
            r_next     = x;
            dbz_next   = 1'b1;
            ovf_next   = 1'b0;
            done_next  = 1'b1;
            state_next = FIX;
          end else begin
            rem_next   = '0;
            quo_next   = x_mag;
            den_next   = y_mag;
            cnt_next   = CW'(N - 1);
`ifdef DIV_SIGNED_EN
            qneg_next  = x_neg ^ y_neg;
            rneg_next  = x_neg;
            ovfp_next  = ovf_hit;
`endif
            state_next = CALC;
          end
        end
      end

      CALC: begin
        rem_next = srem[SPC];
        quo_next = squo[SPC];
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == '0) begin
          // Final step registers the corrected result so q/r are already valid during FIX.
`ifdef DIV_SIGNED_EN
          q_next   = qneg_reg ? -squo[SPC] : squo[SPC];
          r_next   = rneg_reg ? -srem[SPC] : srem[SPC];
          ovf_next = ovfp_reg;
`else
          q_next   = squo[SPC];
          r_next   = srem[SPC];
          ovf_next = 1'b0;
`endif
          dbz_next   = 1'b0;
          done_next  = 1'b1;
          state_next = FIX;
        end
      end

      FIX: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_reg  <= '0;
      quo_reg  <= '0;
      den_reg  <= '0;
      cnt_reg  <= '0;
      q_reg    <= '0;
      r_reg    <= '0;
      dbz_reg  <= 1'b0;
      ovf_reg  <= 1'b0;
      done_reg <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_reg <= 1'b0;
      rneg_reg <= 1'b0;
      ovfp_reg <= 1'b0;
`endif
    end else begin
      rem_reg  <= rem_next;
      quo_reg  <= quo_next;
      den_reg  <= den_next;
      cnt_reg  <= cnt_next;
      q_reg    <= q_next;
      r_reg    <= r_next;
      dbz_reg  <= dbz_next;
      ovf_reg  <= ovf_next;
      done_reg <= done_next;
`ifdef DIV_SIGNED_EN
      qneg_reg <= qneg_next;
      rneg_reg <= rneg_next;
      ovfp_reg <= ovfp_next;
`endif
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign dbz  = dbz_reg;
  assign ovf  = ovf_reg;
  assign q    = q_reg;
  assign r    = r_reg;

endmodule

// File: tb/tb_div_radix.sv
// Scoreboard bench for div_radix: one SPC=1 and one SPC=4 instance, directed vectors, monitor pops on done.
// Signed expectations follow DIV_SIGNED_EN, matching the build of the design.
module tb_div_radix;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, sgn1, start4, sgn4;
  logic [31:0] x1, y1, x4, y4;
  logic        busy1, done1, dbz1, ovf1, busy4, done4, dbz4, ovf4;
  logic [31:0] q1, r1, q4, r4;

  int cyc   = 0;
  int cmp   = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t sb1[$];
  exp_t sb4[$];
  exp_t e1, e4;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_radix #(.DSZ(32), .SPC(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .sgn(sgn1), .x(x1), .y(y1),
    .busy(busy1), .done(done1), .dbz(dbz1), .ovf(ovf1), .q(q1), .r(r1)
  );

  div_radix #(.DSZ(32), .SPC(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .sgn(sgn4), .x(x4), .y(y4),
    .busy(busy4), .done(done4), .dbz(dbz4), .ovf(ovf4), .q(q4), .r(r4)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    cmp++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endfunction

  // Wait for the unit to be idle, drive one request for `hold` cycles and queue its expectation.
  task automatic issue(input int u, input string tag, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                       input logic ed, input logic eo, input int hold, output int acc);
    int   n;
    exp_t e;
    n   = 0;
    acc = -1;
    @(negedge clk);
    while ((u == 1 ? busy1 : busy4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      cmp++;
      fails++;
      $display("FAIL %s_idle_timeout: busy still 1 after %0d cycles, required 0", tag, n);
      return;
    end
    if (u == 1) begin
      start1 = 1'b1; sgn1 = s; x1 = a; y1 = b;
    end else begin
      start4 = 1'b1; sgn4 = s; x4 = a; y4 = b;
    end
    acc   = cyc;
    e.tag = tag; e.q = eq; e.r = er; e.dbz = ed; e.ovf = eo;
    e.cyc = acc + ((b == 32'd0) ? 1 : (u == 1 ? 33 : 9));
    if (u == 1) sb1.push_back(e);
    else        sb4.push_back(e);
    repeat (hold) @(negedge clk);
    if (u == 1) start1 = 1'b0;
    else        start4 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && done1) begin
      if (sb1.size() == 0) begin
        cmp++;
        fails++;
        $display("FAIL u1_unexpected_done: done=1 at cycle %0d, required no pulse", cyc);
      end else begin
        e1 = sb1.pop_front();
        $display("u1 %s: q=%h r=%h dbz=%b ovf=%b cycle=%0d", e1.tag, q1, r1, dbz1, ovf1, cyc);
        chk({"u1 ", e1.tag, " q"},     q1,   e1.q);
        chk({"u1 ", e1.tag, " r"},     r1,   e1.r);
        chk({"u1 ", e1.tag, " dbz"},   dbz1, e1.dbz);
        chk({"u1 ", e1.tag, " ovf"},   ovf1, e1.ovf);
        chk({"u1 ", e1.tag, " cycle"}, cyc,  e1.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done4) begin
      if (sb4.size() == 0) begin
        cmp++;
        fails++;
        $display("FAIL u4_unexpected_done: done=1 at cycle %0d, required no pulse", cyc);
      end else begin
        e4 = sb4.pop_front();
        $display("u4 %s: q=%h r=%h dbz=%b ovf=%b cycle=%0d", e4.tag, q4, r4, dbz4, ovf4, cyc);
        chk({"u4 ", e4.tag, " q"},     q4,   e4.q);
        chk({"u4 ", e4.tag, " r"},     r4,   e4.r);
        chk({"u4 ", e4.tag, " dbz"},   dbz4, e4.dbz);
        chk({"u4 ", e4.tag, " ovf"},   ovf4, e4.ovf);
        chk({"u4 ", e4.tag, " cycle"}, cyc,  e4.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int   a, a0, n;
    exp_t e;
    rst = 1'b1;
    start1 = 1'b0; sgn1 = 1'b0; x1 = '0; y1 = '0;
    start4 = 1'b0; sgn4 = 1'b0; x4 = '0; y4 = '0;
    repeat (3) @(negedge clk);
    start1 = 1'b1; start4 = 1'b1; y1 = 32'd7; y4 = 32'd7;  // start under reset must be ignored
    @(negedge clk);
    chk("rst u1 busy", busy1, 0); chk("rst u1 done", done1, 0); chk("rst u1 dbz", dbz1, 0);
    chk("rst u1 ovf", ovf1, 0);   chk("rst u1 q", q1, 0);       chk("rst u1 r", r1, 0);
    chk("rst u4 busy", busy4, 0); chk("rst u4 done", done4, 0); chk("rst u4 dbz", dbz4, 0);
    chk("rst u4 ovf", ovf4, 0);   chk("rst u4 q", q4, 0);       chk("rst u4 r", r4, 0);
    start1 = 1'b0; start4 = 1'b0;
    rst = 1'b0;

    issue(1, "100/7",        1'b0, 32'd100,      32'd7, 32'd14,       32'd2,   1'b0, 1'b0, 1, a);
    issue(1, "ffffffff/1",   1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0,   1'b0, 1'b0, 1, a);
    issue(1, "5/10",         1'b0, 32'd5,        32'd10, 32'd0,       32'd5,   1'b0, 1'b0, 1, a);
    issue(1, "deadbeef/16",  1'b0, 32'hDEADBEEF, 32'd16, 32'h0DEADBEE, 32'hF, 1'b0, 1'b0, 1, a);
    issue(1, "1234/0",       1'b0, 32'h1234,     32'd0, 32'hFFFFFFFF, 32'h1234, 1'b1, 1'b0, 1, a0);
    issue(1, "49/7 b2b",     1'b0, 32'd49,       32'd7, 32'd7,        32'd0,   1'b0, 1'b0, 1, a);
    chk("b2b accept cycle", a, a0 + 2);
`ifdef DIV_SIGNED_EN
    issue(1, "min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 1'b1, 1, a);
`else
    issue(1, "min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 1'b0, 1, a);
`endif

    // Abort at A+5: no done may follow, outputs clear the next cycle.
    issue(1, "1000/3 abort", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0, 1, a);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    if (sb1.size() > 0) e = sb1.pop_back();
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", busy1, 0);
    chk("abort q", q1, 0);
    chk("abort r", r1, 0);
    repeat (40) @(negedge clk);

    // Start held for 40 cycles: accepts at A and A+34 only.
    issue(1, "200/9 held#1", 1'b0, 32'd200, 32'd9, 32'd22, 32'd2, 1'b0, 1'b0, 40, a);
    e.tag = "200/9 held#2"; e.q = 32'd22; e.r = 32'd2; e.dbz = 1'b0; e.ovf = 1'b0; e.cyc = a + 67;
    if (a >= 0) sb1.push_back(e);

`ifdef DIV_SIGNED_EN
    issue(4, "-100/7",  1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0, 1, a);
    issue(4, "100/-7",  1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 1'b0, 1, a);
    issue(4, "-100/-7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 1'b0, 1, a);
`else
    issue(4, "-100/7",  1'b1, 32'hFFFFFF9C, 32'd7,        32'h24924916, 32'd2,        1'b0, 1'b0, 1, a);
    issue(4, "100/-7",  1'b1, 32'd100,      32'hFFFFFFF9, 32'd0,        32'd100,      1'b0, 1'b0, 1, a);
    issue(4, "-100/-7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd0,        32'hFFFFFF9C, 1'b0, 1'b0, 1, a);
`endif
    issue(4, "1000/10",   1'b0, 32'd1000,     32'd10,     32'd100,     32'd0,        1'b0, 1'b0, 1, a);
    issue(4, "s/0",       1'b1, 32'hFFFFFF9C, 32'd0,      32'hFFFFFFFF, 32'hFFFFFF9C, 1'b1, 1'b0, 1, a);
    issue(4, "12345678/1000", 1'b0, 32'h12345678, 32'h1000, 32'h12345, 32'h678,     1'b0, 1'b0, 1, a);

    n = 0;
    while ((sb1.size() != 0 || sb4.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("u1 pending results", sb1.size(), 0);
    chk("u4 pending results", sb4.size(), 0);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end

endmodule
